muldiv: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv.sv | 137 +++++++++++++
 tb/tb_muldiv.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULDIV_OP_MULT  = 3'd0,
    MULDIV_OP_MULTU = 3'd1,
    MULDIV_OP_DIV   = 3'd2,
    MULDIV_OP_DIVU  = 3'd3,
    MULDIV_OP_MTHI  = 3'd4,
    MULDIV_OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  // Multiply and divide opcodes occupy 0-3; MTHI/MTLO and the unused codes have bit 2 set.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: conditional add for multiply, trial subtract for restoring divide.
module muldiv_step #(
  parameter int WORD_SIZE = 32
) (
  input  logic               is_div,
  input  logic               add_en,
  input  logic [WORD_SIZE:0] x,
  input  logic [WORD_SIZE:0] y,
  output logic [WORD_SIZE:0] res,
  output logic               take
);

  logic [WORD_SIZE+1:0] diff;

  always_comb begin
    diff = {1'b0, x} - {1'b0, y};
    take = 1'b0;
    res  = x;
    if (is_div) begin
      // No borrow out means the divisor fits: keep the difference, quotient bit is 1.
      take = ~diff[WORD_SIZE+1];
      if (take) res = diff[WORD_SIZE:0];
    end else if (add_en) begin
      res = x + y;
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative signed/unsigned multiply and divide holding the HI/LO registers.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  localparam int CNT_WIDTH = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo
);

  localparam int W = WORD_SIZE;

  muldiv_state_e        state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         acc_hi, acc_lo, opnd;
  logic                 div_op, neg_q, neg_r, div0;

  logic                 accept, sgn;
  logic [W-1:0]         a_abs, b_abs;
  logic [W:0]           step_x, step_y, step_res;
  logic                 step_take;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         quo, rem, fix_hi, fix_lo;

  assign accept = start & ~abort & (state == ST_IDLE);
  assign sgn    = (opcode == MULDIV_OP_MULT) | (opcode == MULDIV_OP_DIV);
  assign a_abs  = (sgn & a[W-1]) ? -a : a;
  assign b_abs  = (sgn & b[W-1]) ? -b : b;
  assign busy   = (state != ST_IDLE);

  // Divide feeds the next dividend bit under the partial remainder; multiply keeps a carry bit.
  assign step_x = div_op ? {acc_hi, acc_lo[W-1]} : {1'b0, acc_hi};
  assign step_y = {1'b0, opnd};

  muldiv_step #(.WORD_SIZE(W)) u_step (
    .is_div (div_op),
    .add_en (acc_lo[0]),
    .x      (step_x),
    .y      (step_y),
    .res    (step_res),
    .take   (step_take)
  );

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -acc_lo : acc_lo;
    rem = neg_r ? -acc_hi : acc_hi;
    // Divide by zero leaves |a| as remainder; its sign correction restores a itself.
    if (div0) quo = '1;
    fix_hi = div_op ? rem : prod[2*W-1:W];
    fix_lo = div_op ? quo : prod[W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_arith(opcode)) state_nxt = ST_CALC;
      ST_CALC: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (cnt == 1) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (opcode == MULDIV_OP_MTHI) begin
            hi   <= a;
            done <= 1'b1;
          end else if (opcode == MULDIV_OP_MTLO) begin
            lo   <= a;
            done <= 1'b1;
          end else if (is_arith(opcode)) begin
            div_op <= opcode[1];
            acc_hi <= '0;
            acc_lo <= opcode[1] ? a_abs : b_abs;
            opnd   <= opcode[1] ? b_abs : a_abs;
            neg_q  <= sgn & (a[W-1] ^ b[W-1]);
            neg_r  <= sgn & a[W-1];
            div0   <= (b == '0);
            cnt    <= CNT_WIDTH'(W);
          end
        end
        ST_CALC: if (!abort) begin
          cnt <= cnt - 1'b1;
          if (div_op) begin
            acc_hi <= step_res[W-1:0];
            acc_lo <= {acc_lo[W-2:0], step_take};
          end else begin
            acc_hi <= step_res[W:1];
            acc_lo <= {step_res[0], acc_lo[W-1:1]};
          end
        end
        ST_FIX: if (!abort) begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed table, corner-case sequences and a randomized model check for muldiv.
module tb_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       inout logic [31:0] mhi, inout logic [31:0] mlo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    case (op)
      3'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      3'd1: begin p = {32'd0, xa} * {32'd0, xb}; mhi = p[63:32]; mlo = p[31:0]; end
      3'd2, 3'd3: begin
        if (xb == 0) begin
          mlo = 32'hFFFF_FFFF; mhi = xa;
        end else if (op == 3'd2 && xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000; mhi = 32'd0;
        end else begin
          if (op == 3'd3) begin sa = longint'({32'd0, xa}); sb = longint'({32'd0, xb}); end
          q = sa / sb; r = sa % sb;
          mlo = q[31:0]; mhi = r[31:0];
        end
      end
      3'd4: mhi = xa;
      3'd5: mlo = xa;
      default: ;
    endcase
  endtask

  // Drive one accepted request; lat = clock edges after the accept edge until done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                        output int lat);
    @(negedge clk);
    start = 1'b1; opcode = op; a = xa; b = xb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int lat;
    logic saw_done;
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [2:0] rop;

    tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{3'd1, 32'hFFFF_FFFD, 32'd7,          32'h0000_0006, 32'hFFFF_FFEB};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd3, 32'd7,         32'd2,          32'd1,         32'd3};
    tbl[4] = '{3'd3, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'hFFFF_FFFF};
    tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tbl[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};

    #2 rst_n = 1'b0;
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(tbl[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(tbl[i].lo));
    end

    // MTHI then MTLO on consecutive cycles
    @(negedge clk); start = 1'b1; opcode = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mthi done", 64'(done), 64'd1);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    @(negedge clk); opcode = 3'd5; a = 32'h0000_CAFE;
    @(posedge clk); #1;
    chk("mtlo done", 64'(done), 64'd1);
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo lo", 64'(lo), 64'h0000_CAFE);
    chk("mtlo hi kept", 64'(hi), 64'hDEAD_BEEF);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("mt done drops", 64'(done), 64'd0);

    // Reserved opcodes 6 and 7 do nothing
    for (int op = 6; op < 8; op++) begin
      @(negedge clk); start = 1'b1; opcode = 3'(op); a = 32'h5555_5555;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("op%0d busy", op), 64'(busy), 64'd0);
      chk($sformatf("op%0d done", op), 64'(done), 64'd0);
      chk($sformatf("op%0d hilo", op), {hi, lo}, {32'hDEAD_BEEF, 32'h0000_CAFE});
    end

    // MULT with an ignored DIV start at cycle 10 and abort at cycle 20
    @(negedge clk); start = 1'b1; opcode = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 10); opcode = 3'd2; abort = (k == 20);
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (k == 19) chk("busy before abort", 64'(busy), 64'd1);
      if (k == 20) chk("busy after abort", 64'(busy), 64'd0);
    end
    start = 1'b0; abort = 1'b0;
    chk("abort no done", 64'(saw_done), 64'd0);
    chk("abort no queued op", 64'(busy), 64'd0);
    chk("abort hilo kept", {hi, lo}, {32'hDEAD_BEEF, 32'h0000_CAFE});

    // Reset mid-CALC, checked before any further clock edge
    @(negedge clk); start = 1'b1; opcode = 3'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // start with abort in IDLE: nothing accepted
    run_op(3'd4, 32'h1111_1111, 32'd0, lat);
    chk("mthi latency", 64'(lat), 64'd0);
    @(negedge clk); start = 1'b1; abort = 1'b1; opcode = 3'd5; a = 32'h2222_2222;
    @(posedge clk); #1;
    chk("start+abort mtlo done", 64'(done), 64'd0);
    chk("start+abort mtlo lo", 64'(lo), 64'd0);
    @(negedge clk); opcode = 3'd0;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("start+abort mult busy", 64'(busy), 64'd0);
    chk("start+abort hilo", {hi, lo}, {32'h1111_1111, 32'd0});

    // Randomized back-to-back ops against the reference model
    m_hi = 32'h1111_1111; m_lo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, lat);
      model(rop, ra, rb, m_hi, m_lo);
      chk($sformatf("rand%0d op%0d latency", i, rop), 64'(lat), rop[2] ? 64'd0 : 64'd33);
      chk($sformatf("rand%0d op%0d a=%h b=%h hilo", i, rop, ra, rb), {hi, lo}, {m_hi, m_lo});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
